// File: rtl/sobel_pkg.sv
// Shared definitions for the streaming Sobel edge detector: FSM state type,
// kernel weight constant and the gradient word-width helper.
package sobel_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_t;

    // Sobel kernel weights are 1 (edges) and 2 (middle); the middle weight is a left shift.
    localparam int unsigned SOBEL_MID_SHIFT = 1;

    // Extra bits over the pixel width: x4 kernel gain, sign, and the |Gx|+|Gy| sum.
    function automatic int unsigned grad_w(input int unsigned pix_w);
        return pix_w + 4;
    endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Two cascaded line delays of DEPTH pixels each, advancing only on enable.
// tap1 is the pixel seen DEPTH beats ago, tap2 the one seen 2*DEPTH beats ago.
// Contents are deliberately not reset.
module sobel_linebuf #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap1,
    output logic [WIDTH-1:0] tap2
);

    logic [WIDTH-1:0] line0 [DEPTH];
    logic [WIDTH-1:0] line1 [DEPTH];

    // Shift both lines by one pixel per accepted input beat.
    always_ff @(posedge clk) begin
        if (en) begin
            line0[0] <= din;
            line1[0] <= line0[DEPTH-1];
            for (int unsigned i = 1; i < DEPTH; i++) begin
                line0[i] <= line0[i-1];
                line1[i] <= line1[i-1];
            end
        end
    end

    assign tap1 = line0[DEPTH-1];
    assign tap2 = line1[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector, one output pixel per input pixel.
// Build option: define SOBEL_THRESH_EN to binarise the magnitude against THRESH.
module sobel_stream
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned THRESH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] pixel_out,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned GW = grad_w(PIX_W);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [GW-1:0] MAX_MAG  = {{(GW-PIX_W){1'b0}}, {PIX_W{1'b1}}};
    localparam logic [GW-1:0] THR_MAG  = GW'(THRESH);
`ifdef SOBEL_THRESH_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    in_col_q, out_col_q;
    logic [RW-1:0]    in_row_q, out_row_q;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic             out_valid_q, out_last_q;
    logic [PIX_W-1:0] pixel_out_q;

    logic slot_free, in_beat, out_beat, gen_flush, gen;
    logic [PIX_W-1:0] tap1, tap2;

    assign slot_free  = !out_valid_q || out_ready;
    assign in_ready   = !rst && (((state_q != S_FLUSH) && slot_free) || (state_q == S_FILL));
    assign in_beat    = in_valid && in_ready;
    assign out_beat   = out_valid_q && out_ready;
    assign frame_done = out_beat && out_last_q;
    // Flush produces one output per free slot until the frame's last output is pending.
    assign gen_flush  = (state_q == S_FLUSH) && slot_free && !(out_valid_q && out_last_q);
    assign gen        = ((state_q == S_RUN) && in_beat) || gen_flush;
    assign busy       = (state_q == S_FLUSH);
    assign out_valid  = out_valid_q;
    assign pixel_out  = pixel_out_q;

    sobel_linebuf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_linebuf (
        .clk  (clk),
        .en   (in_beat),
        .din  (pixel_in),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    // Next window: shift left one column; the new right column is rows r-2..r, zeros in flush.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = tap2;
        win_d[1][2] = tap1;
        win_d[2][2] = pixel_in;
        if (state_q == S_FLUSH) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][2] = '0;
            end
        end
    end

    function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] v);
        return $signed({{(GW-PIX_W){1'b0}}, v});
    endfunction

    logic signed [GW-1:0] gx, gy;
    logic [GW-1:0]        abs_gx, abs_gy, mag, mag_sat_w;
    logic [PIX_W-1:0]     mag_sat, result;
    logic                 on_border;

    // Gradients of the window about to be formed, magnitude, saturation, border mask.
    always_comb begin
        gx = (sx(win_d[0][2]) + (sx(win_d[1][2]) <<< SOBEL_MID_SHIFT) + sx(win_d[2][2]))
           - (sx(win_d[0][0]) + (sx(win_d[1][0]) <<< SOBEL_MID_SHIFT) + sx(win_d[2][0]));
        gy = (sx(win_d[2][0]) + (sx(win_d[2][1]) <<< SOBEL_MID_SHIFT) + sx(win_d[2][2]))
           - (sx(win_d[0][0]) + (sx(win_d[0][1]) <<< SOBEL_MID_SHIFT) + sx(win_d[0][2]));
        abs_gx    = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        abs_gy    = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        mag       = abs_gx + abs_gy;
        mag_sat   = (mag > MAX_MAG) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
        mag_sat_w = {{(GW-PIX_W){1'b0}}, mag_sat};
        result    = mag_sat;
        if (BIN_EN) begin
            result = (mag_sat_w >= THR_MAG) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
        end
        // Border centres also hide the wrap-around columns of the raster window.
        on_border = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                    (out_col_q == '0) || (out_col_q == COL_LAST);
        if (on_border) begin
            result = '0;
        end
    end

    // FSM next state: fill one line plus one pixel, run, then flush the tail.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FILL:  if (in_beat && (in_row_q == ROW_ONE) && (in_col_q == '0)) state_d = S_RUN;
            S_RUN:   if (in_beat && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST)) begin
                         state_d = S_FLUSH;
                     end
            S_FLUSH: if (frame_done) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    // State register and raster counters for accepted inputs and generated outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            in_col_q  <= '0;
            in_row_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q <= state_d;
            if (in_beat) begin
                if (in_col_q == COL_LAST) begin
                    in_col_q <= '0;
                    in_row_q <= (in_row_q == ROW_LAST) ? '0 : in_row_q + 1'b1;
                end else begin
                    in_col_q <= in_col_q + 1'b1;
                end
            end
            if (gen) begin
                if (out_col_q == COL_LAST) begin
                    out_col_q <= '0;
                    out_row_q <= (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
                end else begin
                    out_col_q <= out_col_q + 1'b1;
                end
            end
        end
    end

    // Window registers advance with every input beat or flush step.
    always_ff @(posedge clk) begin
        if (in_beat || gen_flush) begin
            win_q <= win_d;
        end
    end

    // One-entry output register, held until the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            pixel_out_q <= '0;
        end else if (gen) begin
            out_valid_q <= 1'b1;
            pixel_out_q <= result;
            out_last_q  <= (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a small 8x6 image: a 2-D convolution
// model fills an expected-output queue, one process compares every output beat.
module tb_sobel_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int N  = W * H;
    localparam int TH = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] pixel_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] pixel_out;
    logic       busy;
    logic       frame_done;

    int   total = 0;
    int   bad = 0;
    int   img [N];
    int   dut_img [N];
    int   exp_q [$];
    bit   last_q [$];
    bit   rand_ready = 1'b0;
    int   out_idx = 0;
    bit   stall_prev = 1'b0;
    logic [7:0] held = '0;
    int   e_v;
    bit   l_v;

    sobel_stream #(
        .IMG_W  (W),
        .IMG_H  (H),
        .PIX_W  (8),
        .THRESH (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pixel_in   (pixel_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pixel_out  (pixel_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int post(input int m);
`ifdef SOBEL_THRESH_EN
        return (m >= TH) ? 255 : 0;
`else
        return m;
`endif
    endfunction

    function automatic int px(input int r, input int c);
        return img[r*W + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Model: direct 3x3 convolution per centre, border forced to zero.
    task automatic push_expected();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int v;
                int gx;
                int gy;
                int m;
                v = 0;
                if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
                    gx = 0;
                    gy = 0;
                    for (int d = -1; d <= 1; d++) begin
                        gx += ((d == 0) ? 2 : 1) * (px(r+d, c+1) - px(r+d, c-1));
                        gy += ((d == 0) ? 2 : 1) * (px(r+1, c+d) - px(r-1, c+d));
                    end
                    m = iabs(gx) + iabs(gy);
                    if (m > 255) m = 255;
                    v = post(m);
                end
                exp_q.push_back(v);
                last_q.push_back(r == H-1 && c == W-1);
            end
        end
    endtask

    // Sink readiness changes just after the rising edge.
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare every output beat against the model queue; check stall hold.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            out_idx    = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_hold", int'(pixel_out), int'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 1, 0);
                end else begin
                    e_v = exp_q.pop_front();
                    l_v = last_q.pop_front();
                    check("pixel_out", int'(pixel_out), e_v);
                    check("frame_done", int'(frame_done), int'(l_v));
                    if (out_idx < N) dut_img[out_idx] = int'(pixel_out);
                    out_idx = l_v ? 0 : out_idx + 1;
                end
            end else begin
                check("frame_done_idle", int'(frame_done), 0);
            end
            stall_prev = out_valid && !out_ready;
            held       = pixel_out;
        end
    end

    task automatic send_px(input int v);
        int n;
        n = 0;
        in_valid = 1'b1;
        pixel_in = 8'(v);
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        last_q.delete();
        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_pixel_out", int'(pixel_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        push_expected();
        for (int k = 0; k < N; k++) send_px(img[k]);
        check("busy_after_last", int'(busy), 1);
        check("in_ready_in_flush", int'(in_ready), 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        #1;
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic pin(input string name, input int r, input int c, input int want);
        check(name, dut_img[r*W + c], want);
    endtask

    task automatic load_step();
        for (int k = 0; k < N; k++) img[k] = ((k % W) >= W/2) ? 255 : 0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) img[k] = (k / W) * 16 + (k % W);
    endtask

    task automatic load_rand();
        for (int k = 0; k < N; k++) img[k] = int'($urandom_range(0, 255));
    endtask

    initial begin
        reset_dut();

        // Flat image: every output zero.
        for (int k = 0; k < N; k++) img[k] = 100;
        run_frame();
        wait_drain();
        pin("flat_2_3", 2, 3, 0);

        // Vertical step at column W/2: centres on both sides of it saturate.
        load_step();
        run_frame();
        wait_drain();
        pin("step_2_3", 2, 3, post(255));
        pin("step_3_4", 3, 4, post(255));
        pin("step_2_2", 2, 2, 0);
        pin("step_2_5", 2, 5, 0);
        pin("step_border_0_4", 0, 4, 0);

        // Ramp row*16+col: Gx=8, Gy=128 -> 136 everywhere inside; random stalls.
        rand_ready = 1'b1;
        load_ramp();
        run_frame();
        wait_drain();
        pin("ramp_1_1", 1, 1, post(136));
        pin("ramp_4_6", 4, 6, post(136));
        pin("ramp_border_5_3", 5, 3, 0);
        pin("ramp_border_1_7", 1, 7, 0);

        // Random image with random sink stalls.
        load_rand();
        run_frame();
        wait_drain();

        // Reset mid-frame, then a clean full frame.
        rand_ready = 1'b0;
        load_rand();
        push_expected();
        for (int k = 0; k < 30; k++) send_px(img[k]);
        reset_dut();
        load_rand();
        run_frame();
        wait_drain();

        // Two frames back to back.
        load_step();
        run_frame();
        load_ramp();
        run_frame();
        wait_drain();
        pin("b2b_ramp_2_2", 2, 2, post(136));
        pin("b2b_ramp_0_0", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
